// File: rtl/block_mover.sv
// Word-by-word memory block mover (memmove semantics) driving a single-port data memory.
// Optional constant-fill mode is compiled in with BLOCK_MOVER_FILL_EN.
module block_mover #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] SrcAddr,
   input  logic [ADDR_W-1:0] DstAddr,
   input  logic [ADDR_W-1:0] Length,
`ifdef BLOCK_MOVER_FILL_EN
   input  logic              Fill,
   input  logic [DATA_W-1:0] FillValue,
`endif
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] MemAddress,
   output logic              MemReadMem,
   output logic              MemWriteMem,
   output logic [DATA_W-1:0] MemWrData,
   input  logic [DATA_W-1:0] MemRdData
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              desc_q, desc_d;
   logic              fill_q, fill_d;

   logic [ADDR_W-1:0] diff;
   logic [ADDR_W-1:0] last;
   logic              go_desc;
   logic              fill_req;
   logic [DATA_W-1:0] fill_val;

`ifdef BLOCK_MOVER_FILL_EN
   assign fill_req = Fill;
   assign fill_val = FillValue;
`else
   assign fill_req = 1'b0;
   assign fill_val = '0;
`endif

   // Destination starting inside the source window means an ascending copy would
   // overwrite source words before reading them, so walk from the top down instead.
   assign diff    = DstAddr - SrcAddr;
   assign last    = Length - ONE;
   assign go_desc = !fill_req && (diff != '0) && (diff < Length);

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      desc_d  = desc_q;
      fill_d  = fill_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               cnt_d  = Length;
               desc_d = go_desc;
               fill_d = fill_req;
               hold_d = fill_req ? fill_val : hold_q;
               src_d  = go_desc ? SrcAddr + last : SrcAddr;
               dst_d  = go_desc ? DstAddr + last : DstAddr;
               if (Length == '0)
                  state_d = S_DONE;
               else if (fill_req)
                  state_d = S_WRITE;
               else
                  state_d = S_READ;
            end
         end
         S_READ: begin
            hold_d  = MemRdData;
            src_d   = desc_q ? src_q - ONE : src_q + ONE;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            dst_d = desc_q ? dst_q - ONE : dst_q + ONE;
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE)
               state_d = S_DONE;
            else if (fill_q)
               state_d = S_WRITE;
            else
               state_d = S_READ;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         desc_q  <= 1'b0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         desc_q  <= desc_d;
         fill_q  <= fill_d;
      end
   end

   // Outputs decode straight from registered state so Reset clears them without a clock.
   assign Busy        = (state_q != S_IDLE);
   assign Done        = (state_q == S_DONE);
   assign MemReadMem  = (state_q == S_READ);
   assign MemWriteMem = (state_q == S_WRITE);
   assign MemAddress  = MemReadMem ? src_q : (MemWriteMem ? dst_q : '0);
   assign MemWrData   = hold_q;

endmodule

// File: tb/tb_block_mover.sv
// Bench for block_mover: directed vector table, reset-abort sequence and randomized
// transfers checked against a memmove-style reference model.
module tb_block_mover;

   logic       CLK = 1'b0;
   logic       Reset, Start;
   logic [7:0] SrcAddr, DstAddr, Length;
   logic       Busy, Done, MemReadMem, MemWriteMem;
   logic [7:0] MemAddress, MemWrData, MemRdData;
`ifdef BLOCK_MOVER_FILL_EN
   logic       Fill;
   logic [7:0] FillValue;
`endif

   logic [7:0] mem [256];
   logic [7:0] rd_q [$];
   int n_pass, n_chk, proto_err, n_wr, n_done_hi;

   block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start),
      .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
`ifdef BLOCK_MOVER_FILL_EN
      .Fill(Fill), .FillValue(FillValue),
`endif
      .Busy(Busy), .Done(Done), .MemAddress(MemAddress),
      .MemReadMem(MemReadMem), .MemWriteMem(MemWriteMem),
      .MemWrData(MemWrData), .MemRdData(MemRdData)
   );

   assign MemRdData = MemReadMem ? mem[MemAddress] : 8'h00;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] src, dst, len;
      int         exp_done;
      int         exp_first;
   } vec_t;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
   endtask

   // One clock cycle, observed mid-cycle; the memory model commits writes here.
   task automatic step(output logic d, output logic b);
      @(negedge CLK);
      d = Done;
      b = Busy;
      if (MemReadMem && MemWriteMem) proto_err++;
      if (!MemReadMem && !MemWriteMem && MemAddress != 8'h00) proto_err++;
      if (Done && (MemReadMem || MemWriteMem)) proto_err++;
      if (Done && !Busy) proto_err++;
      if (MemReadMem) rd_q.push_back(MemAddress);
      if (MemWriteMem) begin
         mem[MemAddress] = MemWrData;
         n_wr++;
      end
   endtask

   task automatic run(input string tag, input logic [7:0] src, input logic [7:0] dst,
                      input logic [7:0] len, input bit fill, input logic [7:0] fval,
                      input bit junk, output int done_cyc, output int busy_cyc);
      logic [7:0] exp [256];
      logic [7:0] tmp [256];
      logic d, b;
      int diffs;
      for (int i = 0; i < 256; i++) exp[i] = mem[i];
      for (int i = 0; i < int'(len); i++) tmp[i] = fill ? fval : mem[(int'(src) + i) & 255];
      for (int i = 0; i < int'(len); i++) exp[(int'(dst) + i) & 255] = tmp[i];
      rd_q.delete();
      n_wr = 0; n_done_hi = 0; done_cyc = -1; busy_cyc = 0;
      @(negedge CLK);
      Start = 1'b1; SrcAddr = src; DstAddr = dst; Length = len;
`ifdef BLOCK_MOVER_FILL_EN
      Fill = fill; FillValue = fval;
`endif
      @(posedge CLK);
      #1;
      Start = 1'b0;
      SrcAddr = 8'($urandom); DstAddr = 8'($urandom); Length = 8'($urandom);
`ifdef BLOCK_MOVER_FILL_EN
      Fill = 1'($urandom); FillValue = 8'($urandom);
`endif
      for (int cyc = 1; cyc <= 2 * int'(len) + 8; cyc++) begin
         step(d, b);
         if (b) busy_cyc++;
         if (d) begin
            n_done_hi++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         Start = (junk && b && !d) ? 1'($urandom) : 1'b0;
         if (done_cyc > 0 && cyc >= done_cyc + 1) break;
      end
      Start = 1'b0;
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp[i]) diffs++;
      chk({tag, " mem_diffs"}, diffs, 0);
      chk({tag, " writes"}, n_wr, int'(len));
      chk({tag, " reads"}, rd_q.size(), fill ? 0 : int'(len));
      chk({tag, " done_pulses"}, n_done_hi, 1);
   endtask

   vec_t vt [9];

   initial begin
      int dc, bc, got;
      logic d, b;
      logic [7:0] orig10;
      logic [7:0] s, t, l;

      vt[0] = '{8'h10, 8'h20, 8'd4, 9, 'h10};
      vt[1] = '{8'h30, 8'h31, 8'd3, 7, 'h32};
      vt[2] = '{8'h50, 8'h60, 8'd0, 1, -1};
      vt[3] = '{8'hFE, 8'h40, 8'd4, 9, 'hFE};
      vt[4] = '{8'h50, 8'h50, 8'd2, 5, 'h50};
      vt[5] = '{8'hFE, 8'hFF, 8'd3, 7, 'h00};
      vt[6] = '{8'h60, 8'h5F, 8'd3, 7, 'h60};
      vt[7] = '{8'h70, 8'h73, 8'd3, 7, 'h70};
      vt[8] = '{8'hFC, 8'hFE, 8'd4, 9, 'hFF};

      Reset = 1'b0; Start = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h00; Length = 8'h00;
`ifdef BLOCK_MOVER_FILL_EN
      Fill = 1'b0; FillValue = 8'h00;
`endif
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      #1 Reset = 1'b1;
      #1;
      chk("reset Busy", int'(Busy), 0);
      chk("reset Done", int'(Done), 0);
      chk("reset MemReadMem", int'(MemReadMem), 0);
      chk("reset MemWriteMem", int'(MemWriteMem), 0);
      chk("reset MemAddress", int'(MemAddress), 0);
      chk("reset MemWrData", int'(MemWrData), 0);
      @(negedge CLK);
      @(negedge CLK);
      Reset = 1'b0;

      for (int k = 0; k < 9; k++) begin
         fill_pattern();
         if (k == 0) begin
            mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
         end
         if (k == 1) begin
            mem[8'h30] = 8'h01; mem[8'h31] = 8'h02; mem[8'h32] = 8'h03;
         end
         run($sformatf("vec%0d", k), vt[k].src, vt[k].dst, vt[k].len, 1'b0, 8'h00, 1'b0, dc, bc);
         chk($sformatf("vec%0d done_cycle", k), dc, vt[k].exp_done);
         chk($sformatf("vec%0d busy_cycles", k), bc, vt[k].exp_done);
         got = (rd_q.size() > 0) ? int'(rd_q[0]) : -1;
         chk($sformatf("vec%0d first_read", k), got, vt[k].exp_first);
         if (k == 0) begin
            chk("vec0 mem20", int'(mem[8'h20]), 'hA1);
            chk("vec0 mem23", int'(mem[8'h23]), 'hD4);
         end
         if (k == 1) begin
            chk("vec1 mem30", int'(mem[8'h30]), 'h01);
            chk("vec1 mem31", int'(mem[8'h31]), 'h01);
            chk("vec1 mem33", int'(mem[8'h33]), 'h03);
         end
         if (k == 3) begin
            got = (rd_q.size() == 4) ? int'({rd_q[0], rd_q[1], rd_q[2], rd_q[3]}) : 0;
            chk("vec3 read_order", got, 'hFEFF0001);
         end
      end

      // Abort a Len=4 copy with Reset during its fourth cycle (second write).
      fill_pattern();
      orig10 = mem[8'h10];
      rd_q.delete(); n_wr = 0; n_done_hi = 0;
      @(negedge CLK);
      Start = 1'b1; SrcAddr = 8'h10; DstAddr = 8'h20; Length = 8'd4;
      @(posedge CLK);
      #1 Start = 1'b0;
      for (int c = 1; c <= 3; c++) step(d, b);
      @(posedge CLK);
      #2 Reset = 1'b1;
      #1;
      chk("abort MemWriteMem", int'(MemWriteMem), 0);
      chk("abort MemReadMem", int'(MemReadMem), 0);
      chk("abort Busy", int'(Busy), 0);
      chk("abort MemAddress", int'(MemAddress), 0);
      chk("abort MemWrData", int'(MemWrData), 0);
      step(d, b);
      Reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step(d, b);
         if (d) n_done_hi++;
      end
      chk("abort writes", n_wr, 1);
      chk("abort done_pulses", n_done_hi, 0);
      chk("abort dst0", int'(mem[8'h20]), int'(orig10));
      chk("abort dst1 untouched", int'(mem[8'h21]), int'(8'h21 ^ 8'h5A));
      run("after_abort", 8'h10, 8'h20, 8'd4, 1'b0, 8'h00, 1'b0, dc, bc);
      chk("after_abort done_cycle", dc, 9);

      // Randomized transfers with Start pulses thrown in while busy.
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         s = 8'($urandom); t = 8'($urandom); l = 8'($urandom_range(0, 24));
         if (r % 5 == 0) t = s + 8'($urandom_range(1, 3));
         run($sformatf("rnd%0d", r), s, t, l, 1'b0, 8'h00, 1'b1, dc, bc);
         chk($sformatf("rnd%0d done_cycle", r), dc, 2 * int'(l) + 1);
      end

`ifdef BLOCK_MOVER_FILL_EN
      fill_pattern();
      run("fill", 8'h00, 8'h80, 8'd3, 1'b1, 8'h5A, 1'b0, dc, bc);
      chk("fill done_cycle", dc, 4);
      chk("fill mem82", int'(mem[8'h82]), 'h5A);
      for (int r = 0; r < 5; r++) begin
         fill_pattern();
         l = 8'($urandom_range(0, 20));
         run($sformatf("rfill%0d", r), 8'($urandom), 8'($urandom), l, 1'b1, 8'($urandom), 1'b1, dc, bc);
         chk($sformatf("rfill%0d done_cycle", r), dc, (l == 8'd0) ? 1 : int'(l) + 1);
      end
`endif

      chk("protocol violations", proto_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
